arb_grant_ctrl: RTL and testbench

- Registered grant-hold controller for up to WIDTH requesters; sits directly downstream of the combinational lowest-index-wins priority pick.
- Samples requests, registers a one-hot grant and holds it until the owner signals done or drops its request.
- Inserts a one-cycle turnaround before re-arbitrating.
- Gives the shared-resource mux a stable, glitch-free select and owner index.

---
 rtl/arb_pkg.sv | 31 +++
 rtl/prio_pick.sv | 19 +
 rtl/arb_grant_ctrl.sv | 162 ++++++++++++++++
 tb/tb_arb_grant_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared definitions for the registered grant-hold arbiter:
//   - arb_state_e     : FSM state encoding (IDLE, GRANT, RELEASE)
//   - ARB_WIDTH_DEF   : default number of requesters
//   - ARB_MAX_HOLD_DEF: default maximum grant duration (timeout build only)
//   - onehot_to_idx() : one-hot vector (up to 64 bits) to binary index
// ---------------------------------------------------------------------------
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    RELEASE = 2'd2
  } arb_state_e;

  localparam int ARB_WIDTH_DEF    = 8;
  localparam int ARB_MAX_HOLD_DEF = 16;

  // OR-reduces the indices of all set bits; exact for one-hot input and
  // returns 0 for an all-zero vector.
  function automatic logic [5:0] onehot_to_idx(input logic [63:0] oh);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = 0; i < 64; i++) begin
      if (oh[i]) idx = idx | 6'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/prio_pick.sv
// ---------------------------------------------------------------------------
// prio_pick
// Purely combinational lowest-index-wins priority picker.
// Ports:
//   req_i  [WIDTH-1:0]  request vector
//   pick_o [WIDTH-1:0]  one-hot of the lowest set bit; all-zero for req_i == 0
// ---------------------------------------------------------------------------
module prio_pick #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] req_i,
  output logic [WIDTH-1:0] pick_o
);

  // Two's-complement trick: req & -req isolates the lowest set bit and
  // naturally yields zero for a zero input.
  assign pick_o = req_i & (~req_i + WIDTH'(1));

endmodule

// File: rtl/arb_grant_ctrl.sv
// ---------------------------------------------------------------------------
// arb_grant_ctrl
// Registered grant-hold controller. Samples the request vector in IDLE,
// registers a one-hot grant for the lowest-index requester and holds it
// until the owner raises its done bit or drops its request, then spends one
// RELEASE cycle with everything cleared before re-arbitrating.
//
// Optional feature (compile-time macro ARB_TIMEOUT_EN): a hold counter
// force-releases a grant after MAX_HOLD cycles and pulses timeout for the
// RELEASE cycle. Without the macro the counter is absent and timeout is 0.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req        in   [WIDTH-1:0] request vector
//   done       in   [WIDTH-1:0] release strobes (owner bit only honoured)
//   gnt        out  [WIDTH-1:0] registered one-hot grant
//   gnt_valid  out  registered, high while gnt is non-zero
//   gnt_id     out  [$clog2(WIDTH)-1:0] registered owner index, 0 when idle
//   timeout    out  registered force-release pulse
// ---------------------------------------------------------------------------
module arb_grant_ctrl
  import arb_pkg::*;
#(
  parameter int WIDTH    = ARB_WIDTH_DEF,
  parameter int MAX_HOLD = ARB_MAX_HOLD_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         req,
  input  logic [WIDTH-1:0]         done,
  output logic [WIDTH-1:0]         gnt,
  output logic                     gnt_valid,
  output logic [$clog2(WIDTH)-1:0] gnt_id,
  output logic                     timeout
);

  localparam int IDW = $clog2(WIDTH);
  localparam int SW  = $bits(arb_state_e);

  localparam logic [SW-1:0] S_IDLE    = IDLE;
  localparam logic [SW-1:0] S_GRANT   = GRANT;
  localparam logic [SW-1:0] S_RELEASE = RELEASE;

  if (MAX_HOLD < 2) begin : g_bad_max_hold
    $error("arb_grant_ctrl: MAX_HOLD must be at least 2");
  end

  logic [SW-1:0]    state_q, state_d;
  logic [WIDTH-1:0] gnt_q, gnt_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic [IDW-1:0]   gnt_id_q, gnt_id_d;
  logic [WIDTH-1:0] pick;
  logic             rel_cond;

  prio_pick #(.WIDTH(WIDTH)) u_pick (
    .req_i  (req),
    .pick_o (pick)
  );

  // Only the current owner's bits matter; foreign done/req are ignored.
  assign rel_cond = done[gnt_id_q] | ~req[gnt_id_q];

`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_HOLD + 1);

  logic [CW-1:0] hold_q, hold_d;
  logic          timeout_q, timeout_d;
`endif

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
`ifdef ARB_TIMEOUT_EN
    hold_d      = hold_q;
    timeout_d   = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d     = S_GRANT;
          gnt_d       = pick;
          gnt_valid_d = 1'b1;
          gnt_id_d    = IDW'(onehot_to_idx(64'(pick)));
`ifdef ARB_TIMEOUT_EN
          hold_d      = '0;
`endif
        end
      end
      S_GRANT: begin
        // A genuine release wins over a coincident timeout limit, so the
        // timeout pulse only appears for a true force-release.
        if (rel_cond) begin
          state_d     = S_RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
        end
`ifdef ARB_TIMEOUT_EN
        else if (hold_q == CW'(MAX_HOLD - 1)) begin
          state_d     = S_RELEASE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          gnt_id_d    = '0;
          timeout_d   = 1'b1;
        end else begin
          hold_d      = hold_q + CW'(1);
        end
`endif
      end
      S_RELEASE: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
      default: begin
        state_d     = S_IDLE;
        gnt_d       = '0;
        gnt_valid_d = 1'b0;
        gnt_id_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  assign timeout = 1'b0;
`endif

  assign gnt       = gnt_q;
  assign gnt_valid = gnt_valid_q;
  assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_arb_grant_ctrl.sv
// ---------------------------------------------------------------------------
// tb_arb_grant_ctrl
// Directed bench for arb_grant_ctrl (WIDTH = 8, MAX_HOLD = 4). Inputs are
// driven 1 time unit after the rising edge and outputs are sampled there.
// ---------------------------------------------------------------------------
module tb_arb_grant_ctrl;

  localparam int WIDTH    = 8;
  localparam int MAX_HOLD = 4;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] req;
  logic [WIDTH-1:0] done;
  logic [WIDTH-1:0] gnt;
  logic             gnt_valid;
  logic [2:0]       gnt_id;
  logic             timeout;

  int n_checks;
  int n_errors;

  arb_grant_ctrl #(
    .WIDTH    (WIDTH),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] e_gnt,
                           input logic [2:0] e_id, input logic e_to);
    check({tag, ".gnt"},       32'(gnt),       32'(e_gnt));
    check({tag, ".gnt_valid"}, 32'(gnt_valid), 32'(e_gnt != 8'h00));
    check({tag, ".gnt_id"},    32'(gnt_id),    32'(e_id));
    check({tag, ".timeout"},   32'(timeout),   32'(e_to));
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst  = 1'b1;
    req  = '0;
    done = '0;

    // Reset state
    #2;
    check_out("reset", 8'h00, 3'd0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Empty request vector for 10 cycles
    for (int i = 0; i < 10; i++) begin
      tick();
      check("empty.gnt",       32'(gnt),       32'h0);
      check("empty.gnt_valid", 32'(gnt_valid), 32'h0);
    end

    // Priority pick: lowest set bit of 1011_0100 is bit 2
    req = 8'b1011_0100;
    tick();
    check_out("pick", 8'h04, 3'd2, 1'b0);
    req = 8'b0000_0101;
    tick();
    check_out("pick_hold1", 8'h04, 3'd2, 1'b0);
    tick();
    check_out("pick_hold2", 8'h04, 3'd2, 1'b0);

    // Release by done while owner keeps requesting
    done = 8'h04;
    tick();
    check_out("done_rel", 8'h00, 3'd0, 1'b0);
    done = 8'h00;
    req  = 8'h01;
    tick();
    check_out("done_idle", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("done_regrant", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    tick();
    check_out("drain0_rel", 8'h00, 3'd0, 1'b0);
    tick();

    // Foreign done ignored, lower-index newcomer ignored
    req = 8'h20;
    tick();
    check_out("own5", 8'h20, 3'd5, 1'b0);
    done = 8'h01;
    tick();
    check_out("foreign_done", 8'h20, 3'd5, 1'b0);
    done = 8'h00;
    req  = 8'h21;
    tick();
    check_out("no_preempt", 8'h20, 3'd5, 1'b0);
    req = 8'h01;
    tick();
    check_out("req_drop_rel", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("req_drop_idle", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("req_drop_regrant", 8'h01, 3'd0, 1'b0);
    req = 8'h00;
    tick();
    tick();

    // done and req drop together: one release, no timeout
    req = 8'h02;
    tick();
    check_out("own1", 8'h02, 3'd1, 1'b0);
    req  = 8'h00;
    done = 8'h02;
    tick();
    check_out("both_rel", 8'h00, 3'd0, 1'b0);
    done = 8'h00;
    tick();
    check_out("both_idle", 8'h00, 3'd0, 1'b0);

    // Owner 7 holds without done
    req = 8'h80;
    tick();
    check_out("own7", 8'h80, 3'd7, 1'b0);
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < MAX_HOLD - 1; i++) begin
      tick();
      check_out("hold7", 8'h80, 3'd7, 1'b0);
    end
    tick();
    check_out("timeout_rel", 8'h00, 3'd0, 1'b1);
    tick();
    check_out("timeout_idle", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("timeout_regrant", 8'h80, 3'd7, 1'b0);
`else
    for (int i = 0; i < 100; i++) begin
      tick();
      check("hold7.gnt",     32'(gnt),     32'h80);
      check("hold7.timeout", 32'(timeout), 32'h0);
    end
`endif
    req = 8'h00;
    tick();
    tick();

    // Asynchronous reset in the middle of a grant
    req = 8'h08;
    tick();
    check_out("own3", 8'h08, 3'd3, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_out("async_rst", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("rst_held", 8'h00, 3'd0, 1'b0);
    rst = 1'b0;
    #1;
    check_out("post_rst_idle", 8'h00, 3'd0, 1'b0);
    tick();
    check_out("post_rst_grant", 8'h08, 3'd3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
